// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_PAT_W = 5;
    localparam logic [DEF_PAT_W-1:0] DEF_PAT = 5'b01010;

    // Ceiling log2, used to size the fill counter for values 0..PAT_W.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a registered all-ones flag.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
            sat <= ((cnt + W'(1)) == '1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector for a run-time programmable PAT_W-bit sync word,
// with overlap/non-overlap modes, input enable and a saturating match count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 5,
    parameter int unsigned      CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_in,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             busy
);

    localparam int unsigned FILL_W = clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    state_t             state;
    logic [PAT_W-1:0]   pat_q;
    logic               ovl_q;
    logic [PAT_W-1:0]   hist;
    logic [FILL_W-1:0]  fill;

    logic [PAT_W-1:0]   hist_next;
    logic [FILL_W-1:0]  fill_next;
    logic               match_c;

    // A match needs a full history after the shift, so partial fills never fire.
    always_comb begin
        hist_next = {hist[PAT_W-2:0], x};
        fill_next = (fill == FULL) ? fill : fill + FILL_W'(1);
        match_c   = en && !pat_load && (fill_next == FULL) && (hist_next == pat_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= RST_PAT;
            ovl_q <= 1'b1;
            hist  <= '0;
            fill  <= '0;
            state <= FILL;
            y     <= 1'b0;
            busy  <= 1'b0;
        end else if (pat_load) begin
            pat_q <= pat_in;
            ovl_q <= overlap_in;
            hist  <= '0;
            fill  <= '0;
            state <= FILL;
            y     <= 1'b0;
            busy  <= 1'b0;
        end else begin
            y <= match_c;
            if (en) begin
                hist <= hist_next;
                if (match_c && !ovl_q) begin
                    // Non-overlap: the matched word is consumed entirely.
                    fill  <= '0;
                    state <= FILL;
                    busy  <= 1'b0;
                end else begin
                    fill  <= fill_next;
                    state <= (fill_next == FULL) ? RUN : FILL;
                    busy  <= (fill_next == FULL);
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (pat_load),
        .inc (match_c),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: default 5-bit detector plus a 2-bit/2-bit-count instance.
module tb_seq_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_en, a_x, a_load, a_ovl;
    logic [4:0] a_pin;
    logic       a_y, a_sat, a_busy;
    logic [7:0] a_cnt;

    logic       b_rst, b_en, b_x, b_load, b_ovl;
    logic [1:0] b_pin;
    logic       b_y, b_sat, b_busy;
    logic [1:0] b_cnt;

    seq_detector_param u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .x(a_x), .pat_load(a_load),
        .pat_in(a_pin), .overlap_in(a_ovl), .y(a_y), .match_cnt(a_cnt),
        .cnt_sat(a_sat), .busy(a_busy)
    );

    seq_detector_param #(.PAT_W(2), .CNT_W(2), .RST_PAT(2'b11)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .x(b_x), .pat_load(b_load),
        .pat_in(b_pin), .overlap_in(b_ovl), .y(b_y), .match_cnt(b_cnt),
        .cnt_sat(b_sat), .busy(b_busy)
    );

    typedef struct {
        int id;
        int y;
        int cnt;
        int sat;
        int busy;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, indexed by instance (0 = a, 1 = b).
    int w[2]    = '{5, 2};
    int rpat[2] = '{10, 3};
    int cmax[2] = '{255, 3};
    int m_pat[2], m_ovl[2], m_nv[2], m_hist[2], m_cnt[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int id, input bit r, input bit ld, input int pin,
                        input bit ov, input bit e, input bit xb);
        exp_t ex;
        int   ey;
        if (id == 0) begin
            a_rst = r; a_load = ld; a_pin = 5'(pin); a_ovl = ov; a_en = e; a_x = xb;
            b_rst = 1'b0; b_load = 1'b0; b_en = 1'b0;
        end else begin
            b_rst = r; b_load = ld; b_pin = 2'(pin); b_ovl = ov; b_en = e; b_x = xb;
            a_rst = 1'b0; a_load = 1'b0; a_en = 1'b0;
        end
        ey = 0;
        if (r) begin
            m_pat[id] = rpat[id]; m_ovl[id] = 1; m_nv[id] = 0; m_hist[id] = 0; m_cnt[id] = 0;
        end else if (ld) begin
            m_pat[id] = pin; m_ovl[id] = int'(ov); m_nv[id] = 0; m_hist[id] = 0; m_cnt[id] = 0;
        end else if (e) begin
            m_hist[id] = ((m_hist[id] << 1) | int'(xb)) & ((1 << w[id]) - 1);
            if (m_nv[id] < w[id]) m_nv[id]++;
            if (m_nv[id] == w[id] && m_hist[id] == m_pat[id]) begin
                ey = 1;
                if (m_cnt[id] < cmax[id]) m_cnt[id]++;
                if (m_ovl[id] == 0) m_nv[id] = 0;
            end
        end
        ex.id = id; ex.y = ey; ex.cnt = m_cnt[id];
        ex.sat = (m_cnt[id] == cmax[id]) ? 1 : 0;
        ex.busy = (m_nv[id] == w[id]) ? 1 : 0;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        if (ex.id == 0) begin
            chk("a.y", 32'(a_y), ex.y);
            chk("a.cnt", 32'(a_cnt), ex.cnt);
            chk("a.sat", 32'(a_sat), ex.sat);
            chk("a.busy", 32'(a_busy), ex.busy);
        end else begin
            chk("b.y", 32'(b_y), ex.y);
            chk("b.cnt", 32'(b_cnt), ex.cnt);
            chk("b.sat", 32'(b_sat), ex.sat);
            chk("b.busy", 32'(b_busy), ex.busy);
        end
    endtask

    // Feed n bits of 'bits', MSB first, with en=1.
    task automatic feed(input int id, input int bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(id, 1'b0, 1'b0, 0, 1'b0, 1'b1, ((bits >> i) & 1) != 0);
        end
    endtask

    task automatic load(input int id, input int pin, input bit ov);
        step(id, 1'b0, 1'b1, pin, ov, 1'b0, 1'b0);
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_x = 1'b0; a_load = 1'b0; a_ovl = 1'b0; a_pin = '0;
        b_rst = 1'b1; b_en = 1'b0; b_x = 1'b0; b_load = 1'b0; b_ovl = 1'b0; b_pin = '0;

        // Reset, then default pattern 01010
        step(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        feed(0, 5'b01010, 5);
        chk("default_y", 32'(a_y), 1);
        chk("default_cnt", 32'(a_cnt), 1);
        chk("default_busy", 32'(a_busy), 1);
        step(0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        chk("y_one_cycle", 32'(a_y), 0);

        // Overlap vs non-overlap on 0101010
        load(0, 5'b01010, 1'b1);
        feed(0, 7'b0101010, 7);
        chk("ovl_cnt", 32'(a_cnt), 2);
        load(0, 5'b01010, 1'b0);
        feed(0, 7'b0101010, 7);
        chk("nonovl_cnt", 32'(a_cnt), 1);

        // Partial history never matches
        load(0, 5'b00000, 1'b1);
        feed(0, 0, 4);
        chk("partial_cnt", 32'(a_cnt), 0);
        feed(0, 0, 1);
        chk("zero_pat_y", 32'(a_y), 1);

        // en gating
        load(0, 5'b01010, 1'b1);
        feed(0, 3'b010, 3);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, (i % 2) == 0);
        feed(0, 2'b10, 2);
        chk("en_gate_cnt", 32'(a_cnt), 1);

        // Reset mid-stream, including rst over pat_load priority
        feed(0, 4'b0101, 4);
        step(0, 1'b1, 1'b1, 5'b11111, 1'b0, 1'b1, 1'b0);
        feed(0, 0, 1);
        chk("midrst_cnt", 32'(a_cnt), 0);
        chk("midrst_busy", 32'(a_busy), 0);
        feed(0, 5'b01010, 5);
        chk("midrst_match", 32'(a_cnt), 1);

        // pat_load discards x on that edge and restarts fill
        feed(0, 4'b0101, 4);
        step(0, 1'b0, 1'b1, 5'b10101, 1'b1, 1'b1, 1'b0);
        feed(0, 5'b10101, 5);
        chk("load_cnt", 32'(a_cnt), 1);

        // Saturation on the 2-bit instance
        step(1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        feed(1, 6'b111111, 6);
        chk("sat_cnt", 32'(b_cnt), 3);
        chk("sat_flag", 32'(b_sat), 1);
        load(1, 2'b10, 1'b0);
        chk("sat_clr", 32'(b_sat), 0);
        feed(1, 8'b10101010, 8);

        // Random traffic on the 5-bit instance
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                load(0, int'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
            end else if ($urandom_range(0, 99) == 0) begin
                step(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            end else begin
                step(0, 1'b0, 1'b0, 0, 1'b0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector. It is the next generation of the fixed 01010 Mealy/Moore detector FSM.
- Pattern width is a parameter; the pattern value is loaded at run time.
- Overlapping and non-overlapping match modes are selectable.
- Adds an input-enable qualifier and a saturating match counter.
- Sits on a 1-bit serial data path and flags occurrences of a programmable sync word.

Parameters:
PAT_W, 5, pattern length in bits (>=2).
CNT_W, 8, width of the match counter.
RST_PAT, 5'b01010 (PAT_W bits), pattern value loaded by reset.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous reset, active-high.
en  in  1  when 1, x is sampled on this edge; when 0, the detector holds all state.
x  in  1  serial data bit.
pat_load  in  1  1-cycle strobe; latches pat_in and overlap_in, then restarts detection.
pat_in  in  PAT_W  new pattern; MSB is the first bit received.
overlap_in  in  1  mode latched with pat_load: 1 = overlapping, 0 = non-overlapping.
y  out  1  registered 1-cycle match pulse.
match_cnt  out  CNT_W  number of matches since reset/load; saturating.
cnt_sat  out  1  high while match_cnt is at all-ones.
busy  out  1  high in the RUN state, i.e. the history holds PAT_W valid bits.

Behaviour:
- One clock domain. All flops update on rising clk. Reset is synchronous and active-high (clk, rst).
- Reset values:
  - pattern register = RST_PAT; overlap register = 1.
  - history shift register = 0; fill counter = 0; state = FILL.
  - y = 0, match_cnt = 0, cnt_sat = 0, busy = 0.
- Internal state:
  - hist[PAT_W-1:0] shift register: hist <= {hist[PAT_W-2:0], x} on each enabled edge.
  - fill counter, 0..PAT_W, counting valid history bits.
- FSM states:
  - FILL: fill < PAT_W. Each enabled edge shifts x and increments fill. When the next shifted value would give fill == PAT_W, state goes to RUN.
  - RUN: history is full. Each enabled edge shifts x and performs the compare.
- Match condition: the shifted-in next value hist_next == pattern reg, evaluated on an enabled edge, with the history full after the shift (fill_next == PAT_W).
  - Partial history must never match, even if pattern bits equal the reset zeros.
- On a match:
  - y = 1 in the following cycle (registered, latency one clock after the edge sampling the last pattern bit). y is 1 for exactly one cycle, then 0.
  - match_cnt increments by 1 unless it is already all-ones, in which case it holds.
  - cnt_sat = (match_cnt == all-ones), registered alongside match_cnt.
- Non-overlap mode, after a match: fill <= 0, state <= FILL. Bits of the matched word are not reused.
- Overlap mode, after a match: stay in RUN with full history, so a suffix may start the next match.
- en = 0: hold hist, fill, state and match_cnt; y = 0 on the next cycle.
- pat_load = 1 (priority over en/x on that edge):
  - latch pat_in and overlap_in; clear hist, fill and match_cnt; state <= FILL; y = 0.
  - x on that edge is discarded.
- rst has priority over pat_load.
- rst asserted mid-stream: the next edge restores every reset value, including the pattern back to RST_PAT. A partial match is lost.
- busy = (state == RUN).

Decomposition:
- Shared package seq_det_pkg holds:
  - state enum {FILL, RUN} (1-bit encoding);
  - default pattern constant (01010);
  - function clog2 for the fill counter width, $clog2(PAT_W+1).
- One natural sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, cnt, sat). It implements match_cnt and cnt_sat and is reusable elsewhere.
- Shift register, compare and FSM stay in the top module.

Test Plan:
- Reset/default pattern: rst=1 for 2 cycles, then en=1 with x stream 0,1,0,1,0 -> y=1 exactly one cycle after the 5th sampling edge, match_cnt=1, busy=1 after the 5th bit.
- Overlap vs non-overlap:
  - Stream 0101010 in overlap mode -> 2 y pulses (after bits 5 and 7), match_cnt=2.
  - Same stream after pat_load with overlap_in=0 -> 1 pulse, match_cnt=1.
- No false match on partial history: pat_load pat_in=00000, then feed 0,0,0,0 -> y stays 0. Fifth 0 -> y=1.
- en gating: feed 0,1,0 with en=1, hold en=0 for 3 cycles while toggling x, then 1,0 with en=1 -> exactly 1 match; y=0 during the en=0 cycles.
- Saturation: CNT_W=2, overlap mode, pattern 11, 6 consecutive 1s -> match_cnt sequence 1,2,3,3,3, cnt_sat=1 from the third match onward.
- Reset mid-operation: after 0,1,0,1 assert rst for 1 cycle, then feed 0 -> no match. Count and y stay 0 and busy=0. A full 01010 afterwards -> a single match.
